// File: rtl/clock_ctrl_fsm.sv
// Front-panel controller: key synchronise/debounce plus RUN/SET_TIME/SET_DATE mode FSM.
// Optional add-key auto-repeat is built when KEY_AUTO_REPEAT_EN is defined.
module clock_ctrl_fsm #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TIMEOUT_CYC  = 64
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_shift,
  input  logic       key_add,
  output logic       set_time_en,
  output logic       set_date_en,
  output logic       set_time_shift,
  output logic       set_time_add,
  output logic [1:0] mode_state
);

  localparam int unsigned DW     = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned K_MODE  = 0;
  localparam int unsigned K_SHIFT = 1;
  localparam int unsigned K_ADD   = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_TIME = 2'd1,
    SET_DATE = 2'd2
  } mode_t;

  logic [2:0]    raw, sync1, sync2, lvl, flip, press;
  logic [DW-1:0] db_cnt [3];

  mode_t         state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic          in_set, timeout, fwd, add_go, shift_go, rpt_fire;

  assign raw = {key_add, key_shift, key_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] != lvl[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC)) begin
            lvl[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // flip is the cycle the debounced level changes; a rising flip is a press event
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < 3; i++)
      flip[i] = (sync2[i] != lvl[i]) && (db_cnt[i] == DW'(DEBOUNCE_CYC));
    press = flip & sync2;
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_on, rpt_phase;

  always_comb begin
    rpt_fire = rpt_on && in_set && lvl[K_ADD] && !flip[K_ADD] && !press[K_MODE] &&
               (rpt_cnt == (rpt_phase ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_on    <= 1'b0;
      rpt_phase <= 1'b0;
      rpt_cnt   <= '0;
    end else if (press[K_ADD] && in_set && !press[K_MODE]) begin
      rpt_on    <= 1'b1;
      rpt_phase <= 1'b0;
      rpt_cnt   <= '0;
    end else if (rpt_on) begin
      if (!in_set || !lvl[K_ADD] || flip[K_ADD] || press[K_MODE] || state_nxt == RUN) begin
        rpt_on    <= 1'b0;
        rpt_phase <= 1'b0;
        rpt_cnt   <= '0;
      end else if (rpt_fire) begin
        rpt_phase <= 1'b1;
        rpt_cnt   <= '0;
      end else if (rpt_cnt != RW'(RMAX)) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // mode beats add/shift; any key activity in the expiring cycle defers the timeout
  always_comb begin
    in_set    = (state != RUN);
    timeout   = in_set && (to_cnt == TW'(TIMEOUT_CYC - 1)) && !(|press) && !rpt_fire;
    state_nxt = state;
    if (press[K_MODE]) begin
      case (state)
        RUN:      state_nxt = SET_TIME;
        SET_TIME: state_nxt = SET_DATE;
        default:  state_nxt = RUN;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end
    fwd      = in_set && !press[K_MODE];
    add_go   = fwd && (press[K_ADD] || rpt_fire);
    shift_go = fwd && press[K_SHIFT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      to_cnt         <= '0;
      mode_state     <= '0;
      set_time_en    <= 1'b0;
      set_date_en    <= 1'b0;
      set_time_add   <= 1'b0;
      set_time_shift <= 1'b0;
    end else begin
      state          <= state_nxt;
      mode_state     <= state_nxt;
      set_time_en    <= (state_nxt == SET_TIME);
      set_date_en    <= (state_nxt == SET_DATE);
      set_time_add   <= add_go;
      set_time_shift <= shift_go;
      if (state_nxt != state || state_nxt == RUN || |press || rpt_fire)
        to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC - 1))
        to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_ctrl_fsm.sv
// Directed bench for clock_ctrl_fsm: mode cycling, debounce, strobe gating, timeout, reset.
module tb_clock_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] keys;
  logic       set_time_en, set_date_en, set_time_shift, set_time_add;
  logic [1:0] mode_state;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int add_cnt = 0;
  int shift_cnt = 0;
  int both_cnt = 0;
  int add_last = -1;

  clock_ctrl_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_mode       (keys[0]),
    .key_shift      (keys[1]),
    .key_add        (keys[2]),
    .set_time_en    (set_time_en),
    .set_date_en    (set_date_en),
    .set_time_shift (set_time_shift),
    .set_time_add   (set_time_add),
    .mode_state     (mode_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (set_time_add) begin
      add_cnt  <= add_cnt + 1;
      add_last <= cyc;
    end
    if (set_time_shift) shift_cnt <= shift_cnt + 1;
    if (set_time_add && set_time_shift) both_cnt <= both_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_key(input int k, input int hold);
    keys[k] = 1'b1;
    step(hold);
    keys[k] = 1'b0;
    step(10);
  endtask

  task automatic check_outs(input string tag, input int ms, input int te, input int de);
    check({tag, "_mode"}, int'(mode_state), ms);
    check({tag, "_ten"}, int'(set_time_en), te);
    check({tag, "_den"}, int'(set_date_en), de);
  endtask

  int k, a0, s0, b0;

  initial begin
    rst_n = 1'b0;
    keys  = '0;
    step(3);
    check_outs("rst", 0, 0, 0);
    check("rst_add", int'(set_time_add), 0);
    check("rst_shift", int'(set_time_shift), 0);
    rst_n = 1'b1;
    step(5);
    check_outs("post_rst", 0, 0, 0);

    // 1: mode cycling with exact latency
    keys[0] = 1'b1;
    k = cyc;
    step(6);
    check("mode_lat_pre", int'(mode_state), 0);
    step(1);
    check_outs("t1_settime", 1, 1, 0);
    step(3);
    keys[0] = 1'b0;
    step(10);
    check("t1_single_event", int'(mode_state), 1);
    press_key(0, 10);
    check_outs("t1_setdate", 2, 0, 1);
    press_key(0, 10);
    check_outs("t1_run", 0, 0, 0);

    // 2: glitch rejection then one strobe at edge N+7
    press_key(0, 10);
    a0 = add_cnt;
    keys[2] = 1'b1;
    step(3);
    keys[2] = 1'b0;
    step(12);
    check("t2_glitch", add_cnt - a0, 0);
    keys[2] = 1'b1;
    k = cyc;
    step(10);
    keys[2] = 1'b0;
    step(10);
    check("t2_one_strobe", add_cnt - a0, 1);
    check("t2_strobe_cyc", add_last, k + 7);

    // 3: RUN discards, SET forwards add+shift together
    press_key(0, 10);
    press_key(0, 10);
    check("t3_in_run", int'(mode_state), 0);
    a0 = add_cnt; s0 = shift_cnt; b0 = both_cnt;
    keys[2] = 1'b1; keys[1] = 1'b1;
    step(10);
    keys = '0;
    step(10);
    check("t3_run_add", add_cnt - a0, 0);
    check("t3_run_shift", shift_cnt - s0, 0);
    press_key(0, 10);
    keys[2] = 1'b1; keys[1] = 1'b1;
    step(10);
    keys = '0;
    step(10);
    check("t3_set_add", add_cnt - a0, 1);
    check("t3_set_shift", shift_cnt - s0, 1);
    check("t3_same_cycle", both_cnt - b0, 1);

    // 4: timeout boundary, then timeout deferred by a shift press
    press_key(0, 10);
    press_key(0, 10);
    check("t4_run", int'(mode_state), 0);
    a0 = add_cnt; s0 = shift_cnt;
    keys[0] = 1'b1;
    k = cyc;
    step(7);
    check("t4_enter", int'(mode_state), 1);
    step(3);
    keys[0] = 1'b0;
    step(60);
    check("t4_before_to", int'(mode_state), 1);
    step(1);
    check_outs("t4_timeout", 0, 0, 0);
    check("t4_no_add", add_cnt - a0, 0);
    check("t4_no_shift", shift_cnt - s0, 0);

    keys[0] = 1'b1;
    step(10);
    keys[0] = 1'b0;
    step(40);
    keys[1] = 1'b1;
    step(10);
    keys[1] = 1'b0;
    step(11);
    check("t4_deferred", int'(mode_state), 1);
    step(49);
    check("t4_deferred_end", int'(mode_state), 1);
    step(1);
    check("t4_deferred_to", int'(mode_state), 0);
    check("t4_shift_seen", shift_cnt - s0, 1);

    // 5: simultaneous mode+add, async reset, key held across reset release
    press_key(0, 10);
    a0 = add_cnt;
    keys[0] = 1'b1; keys[2] = 1'b1;
    step(10);
    keys = '0;
    step(10);
    check_outs("t5_mode_wins", 2, 0, 1);
    check("t5_add_dropped", add_cnt - a0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("t5_async_rst", 0, 0, 0);
    keys[0] = 1'b1;
    step(3);
    a0 = add_cnt; s0 = shift_cnt;
    rst_n = 1'b1;
    step(20);
    check("t5_held_press", int'(mode_state), 1);
    keys[0] = 1'b0;
    step(10);
    check("t5_held_once", int'(mode_state), 1);
    check("t5_no_rel_add", add_cnt - a0, 0);
    check("t5_no_rel_shift", shift_cnt - s0, 0);

    // 6: long add hold
    a0 = add_cnt;
    keys[2] = 1'b1;
    k = cyc;
    step(40);
    keys[2] = 1'b0;
    step(12);
`ifdef KEY_AUTO_REPEAT_EN
    check("t6_repeat_cnt", add_cnt - a0, 7);
    check("t6_last_cyc", add_last, k + 43);
`else
    check("t6_single", add_cnt - a0, 1);
    check("t6_cyc", add_last, k + 7);
`endif
    check("t6_still_set", int'(mode_state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
